// File: rtl/input_conditioner.sv
// Per-channel debouncer with one-cycle rise/fall pulses, paced by a shared sample tick.
// Define INPUT_CONDITIONER_SYNC_EN to insert a 2-flop synchronizer per channel ahead of the debouncer.
module input_conditioner #(
   parameter int WIDTH          = 1,
   parameter int SAMPLE_CNT_MAX = 25000,
   parameter int PULSE_CNT_MAX  = 150
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sync_in,
   output logic [WIDTH-1:0] debounced_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);
   localparam int SCW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
   localparam int PCW = $clog2(PULSE_CNT_MAX + 1);
   localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);
   localparam logic [PCW-1:0] PULSE_LAST  = PCW'(PULSE_CNT_MAX - 1);

   logic [SCW-1:0]            sample_cnt_r;
   logic [SCW-1:0]            sample_cnt_nxt_s;
   logic                      sample_tick_s;
   logic [WIDTH-1:0]          chan_in_s;
   logic [WIDTH-1:0][PCW-1:0] chan_cnt_r;
   logic [WIDTH-1:0][PCW-1:0] chan_cnt_nxt_s;
   logic [WIDTH-1:0]          level_nxt_s;
   logic [WIDTH-1:0]          prev_r;

`ifdef INPUT_CONDITIONER_SYNC_EN
   logic [WIDTH-1:0] sync_meta_r;
   logic [WIDTH-1:0] sync_stage_r;

   // Two-flop synchronizer so sync_in may be fully asynchronous to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta_r  <= {WIDTH{1'b0}};
         sync_stage_r <= {WIDTH{1'b0}};
      end else begin
         sync_meta_r  <= sync_in;
         sync_stage_r <= sync_meta_r;
      end
   end

   assign chan_in_s = sync_stage_r;
`else
   assign chan_in_s = sync_in;
`endif

   // Free-running sample counter; the tick is its last count, so SAMPLE_CNT_MAX=1 ticks every cycle.
   always_comb begin
      sample_tick_s = (sample_cnt_r == SAMPLE_LAST);
      if (sample_tick_s) begin
         sample_cnt_nxt_s = {SCW{1'b0}};
      end else begin
         sample_cnt_nxt_s = sample_cnt_r + SCW'(1);
      end
   end

   // Per-channel run counter of consecutive differing samples; the level flips on the last one.
   always_comb begin
      chan_cnt_nxt_s = chan_cnt_r;
      level_nxt_s    = debounced_out;
      for (int i = 0; i < WIDTH; i++) begin
         if (!sample_tick_s) begin
            chan_cnt_nxt_s[i] = chan_cnt_r[i];
         end else if (chan_in_s[i] == debounced_out[i]) begin
            chan_cnt_nxt_s[i] = {PCW{1'b0}};
         end else if (chan_cnt_r[i] == PULSE_LAST) begin
            chan_cnt_nxt_s[i] = {PCW{1'b0}};
            level_nxt_s[i]    = chan_in_s[i];
         end else begin
            chan_cnt_nxt_s[i] = chan_cnt_r[i] + PCW'(1);
         end
      end
   end

   // State registers; asynchronous reset drops all partial debounce progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt_r  <= {SCW{1'b0}};
         chan_cnt_r    <= {(WIDTH*PCW){1'b0}};
         debounced_out <= {WIDTH{1'b0}};
         prev_r        <= {WIDTH{1'b0}};
      end else begin
         sample_cnt_r  <= sample_cnt_nxt_s;
         chan_cnt_r    <= chan_cnt_nxt_s;
         debounced_out <= level_nxt_s;
         prev_r        <= debounced_out;
      end
   end

   // Pulses come only from registers, so they appear in the first cycle the new level is visible.
   assign rise_pulse = debounced_out & ~prev_r;
   assign fall_pulse = ~debounced_out & prev_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations plus randomized
// stimulus, all checked every cycle against a sample-history model of the debounce rule.
module tb_input_conditioner;
   localparam int W = 2;
   localparam int S = 4;
   localparam int P = 3;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b0;
   logic [W-1:0] sync_in = 2'b00;
   logic [W-1:0] debounced_out;
   logic [W-1:0] rise_pulse;
   logic [W-1:0] fall_pulse;

   int n_vec = 0;
   int n_err = 0;

   input_conditioner #(
      .WIDTH(W),
      .SAMPLE_CNT_MAX(S),
      .PULSE_CNT_MAX(P)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sync_in(sync_in),
      .debounced_out(debounced_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the level of a channel flips once the last P tick samples taken since its
   // previous change all disagree with it. Ticks fall on cycles where cycle % S == S-1.
   logic [W-1:0] m_out;
   logic [W-1:0] m_prev;
   int           m_cyc;
   logic [15:0]  smp [W];
   int           nsmp [W];

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_deb", debounced_out, 2'b00);
         chk("reset_rise", rise_pulse, 2'b00);
         chk("reset_fall", fall_pulse, 2'b00);
         m_out  = 2'b00;
         m_prev = 2'b00;
         m_cyc  = 0;
         for (int ch = 0; ch < W; ch++) begin
            smp[ch]  = 16'h0000;
            nsmp[ch] = 0;
         end
      end else begin
         chk("model_deb", debounced_out, m_out);
         chk("model_rise", rise_pulse, m_out & ~m_prev);
         chk("model_fall", fall_pulse, ~m_out & m_prev);
         m_prev = m_out;
         if ((m_cyc % S) == (S - 1)) begin
            for (int ch = 0; ch < W; ch++) begin
               logic all_diff;
               smp[ch]  = {smp[ch][14:0], sync_in[ch]};
               nsmp[ch] = nsmp[ch] + 1;
               all_diff = 1'b1;
               for (int k = 0; k < P; k++) begin
                  if (smp[ch][k] == m_out[ch]) all_diff = 1'b0;
               end
               if (nsmp[ch] >= P && all_diff) begin
                  m_out[ch] = sync_in[ch];
                  smp[ch]   = 16'h0000;
                  nsmp[ch]  = 0;
               end
            end
         end
         m_cyc++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the bench at the start of cycle 0 after release.
   task automatic reset_release(input logic [W-1:0] v);
      rst_n   = 1'b0;
      sync_in = v;
      step(3);
      chk("in_reset_deb", debounced_out, 2'b00);
      chk("in_reset_rise", rise_pulse, 2'b00);
      rst_n = 1'b1;
   endtask

   initial begin
      int hold;

      // Reset and first change: ticks at 3, 7, 11 so the level appears in cycle 12.
      reset_release(2'b11);
      step(11);
      chk("s1_deb_c11", debounced_out, 2'b00);
      step(1);
      chk("s1_deb_c12", debounced_out, 2'b11);
      chk("s1_rise_c12", rise_pulse, 2'b11);
      step(1);
      chk("s1_rise_c13", rise_pulse, 2'b00);
      chk("s1_deb_c13", debounced_out, 2'b11);

      // Glitch: samples 1, 1, 0 never complete a run of three.
      reset_release(2'b01);
      step(9);
      sync_in = 2'b00;
      step(11);
      chk("s2_deb_c20", debounced_out, 2'b00);

      // Falling edge launched right after a tick.
      reset_release(2'b01);
      step(12);
      chk("s3_deb_c12", debounced_out, 2'b01);
      chk("s3_rise_c12", rise_pulse, 2'b01);
      sync_in = 2'b00;
      step(11);
      chk("s3_deb_c23", debounced_out, 2'b01);
      step(1);
      chk("s3_deb_c24", debounced_out, 2'b00);
      chk("s3_fall_c24", fall_pulse, 2'b01);
      step(1);
      chk("s3_fall_c25", fall_pulse, 2'b00);

      // Independence: channel 1 lags channel 0 by exactly one tick period.
      reset_release(2'b01);
      step(4);
      sync_in = 2'b11;
      step(8);
      chk("s4_deb_c12", debounced_out, 2'b01);
      chk("s4_rise_c12", rise_pulse, 2'b01);
      step(3);
      chk("s4_deb_c15", debounced_out, 2'b01);
      step(1);
      chk("s4_deb_c16", debounced_out, 2'b11);
      chk("s4_rise_c16", rise_pulse, 2'b10);

      // Asynchronous reset between the 2nd and 3rd tick of a pending change.
      reset_release(2'b01);
      step(12);
      chk("s5_deb_c12", debounced_out, 2'b01);
      sync_in = 2'b11;
      step(9);
      #2 rst_n = 1'b0;
      #1;
      chk("s5_async_deb", debounced_out, 2'b00);
      chk("s5_async_rise", rise_pulse, 2'b00);
      chk("s5_async_fall", fall_pulse, 2'b00);
      step(2);
      reset_release(2'b11);
      step(11);
      chk("s5_deb_c11", debounced_out, 2'b00);
      step(1);
      chk("s5_deb_c12b", debounced_out, 2'b11);
      chk("s5_rise_c12b", rise_pulse, 2'b11);

      // Randomized levels with varied hold times and occasional mid-cycle resets.
      hold = 0;
      for (int k = 0; k < 4000; k++) begin
         if (hold == 0) begin
            sync_in = 2'($urandom_range(0, 3));
            hold    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(1, 14);
         end
         hold--;
         if ($urandom_range(0, 599) == 0) begin
            #2 rst_n = 1'b0;
            step(2);
            rst_n = 1'b1;
         end
         step(1);
      end

      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
